// File: rtl/rshift_pkg.sv
// Shared types and constants for the right-shift request controller.
// Optional feature macro: RSHIFT_CTRL_STICKY_EN (adds a per-request sticky bit).
package rshift_pkg;

    localparam int RSHIFT_WIDTH = 4;
    localparam int RSHIFT_SEL_W = 2;

    // One queued shift request in its canonical layout.
    typedef struct packed {
        logic [RSHIFT_WIDTH-1:0] data;
        logic [RSHIFT_SEL_W-1:0] amt;
`ifdef RSHIFT_CTRL_STICKY_EN
        logic                    sticky;
`endif
    } rshift_req_t;

    // Output holding register state: empty or holding a result.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } rshift_state_t;

endpackage

// File: rtl/rshift_req_fifo.sv
// Generic DEPTH x ENTRY_W synchronous FIFO with a combinational head view.
// The head reads zero while empty; all entries clear on reset.
module rshift_req_fifo #(
    parameter int DEPTH   = 2,
    parameter int ENTRY_W = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [ENTRY_W-1:0]       push_entry,
    input  logic                     pop,
    output logic [ENTRY_W-1:0]       head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = 1;
    localparam logic [PTR_W:0]   CNT_ONE = 1;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;

    // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/rshift_req_ctrl.sv
// Registered front end for the 4-bit combinational right barrel shifter.
// Requests are queued in a small FIFO, the FIFO head drives the shifter and
// the shifter result is captured into a holding register with valid/ready.
// Optional feature macro: RSHIFT_CTRL_STICKY_EN (adds out_sticky).
module rshift_req_ctrl
    import rshift_pkg::*;
#(
    parameter int WIDTH = RSHIFT_WIDTH,
    parameter int SEL_W = RSHIFT_SEL_W,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0] in_amt,
    output logic [WIDTH-1:0] sh_data,
    output logic [SEL_W-1:0] sh_sel,
    input  logic [WIDTH-1:0] sh_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
`ifdef RSHIFT_CTRL_STICKY_EN
    output logic             out_sticky,
`endif
    output logic             busy
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
`ifdef RSHIFT_CTRL_STICKY_EN
    localparam int STICKY_W = 1;
`else
    localparam int STICKY_W = 0;
`endif
    localparam int ENTRY_W = WIDTH + SEL_W + STICKY_W;

    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head;
    logic [CNT_W-1:0]   count;
    logic               push;
    logic               load;
    rshift_state_t      state_q;
    rshift_state_t      state_d;
    logic [WIDTH-1:0]   out_data_p1;

`ifdef RSHIFT_CTRL_STICKY_EN
    logic               out_sticky_p1;

    // True when any bit below the shift amount is set, i.e. lost by the shift.
    function automatic logic shifted_out_any(input logic [WIDTH-1:0] d,
                                             input logic [SEL_W-1:0] a);
        logic any;
        any = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i < int'(a)) begin
                any = any | d[i];
            end
        end
        return any;
    endfunction

    assign push_entry = {in_data, in_amt, shifted_out_any(in_data, in_amt)};
`else
    assign push_entry = {in_data, in_amt};
`endif

    // in_ready is forced low during reset and never looks at a same-cycle pop.
    assign in_ready = rst_n && (count != CNT_FULL);
    assign push     = in_valid && in_ready;
    assign out_valid = (state_q == ST_FULL);
    assign load     = (count != '0) && (!out_valid || out_ready);

    rshift_req_fifo #(
        .DEPTH   (DEPTH),
        .ENTRY_W (ENTRY_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (load),
        .head       (head),
        .count      (count)
    );

    assign sh_sel  = head[STICKY_W +: SEL_W];
    assign sh_data = head[STICKY_W + SEL_W +: WIDTH];

    // Holding register state update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: fill on load, empty when drained with nothing new to load.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (load) state_d = ST_FULL;
            ST_FULL:  if (out_ready && !load) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // ---- stage p1: capture shifter result; hold it until the next load ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_p1 <= '0;
        end else if (load) begin
            out_data_p1 <= sh_result;
        end
    end

`ifdef RSHIFT_CTRL_STICKY_EN
    // Sticky flag travels with its result under the same load/hold rule.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sticky_p1 <= 1'b0;
        end else if (load) begin
            out_sticky_p1 <= head[0];
        end
    end

    assign out_sticky = out_sticky_p1;
`endif

    assign out_data = out_data_p1;
    assign busy     = (count != '0) || out_valid;

endmodule

// File: tb/tb_rshift_req_ctrl.sv
// Self-checking bench for rshift_req_ctrl with a queue-based reference model.
// Honours RSHIFT_CTRL_STICKY_EN when defined for the build.
module tb_rshift_req_ctrl;
    import rshift_pkg::*;

    localparam int DEPTH = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic [1:0] in_amt;
    logic [3:0] sh_data;
    logic [1:0] sh_sel;
    logic [3:0] sh_result;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic       busy;
`ifdef RSHIFT_CTRL_STICKY_EN
    logic       out_sticky;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Stand-in for the combinational shifter the parent would instantiate.
    assign sh_result = sh_data >> sh_sel;

    rshift_req_ctrl #(.WIDTH(4), .SEL_W(2), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_amt     (in_amt),
        .sh_data    (sh_data),
        .sh_sel     (sh_sel),
        .sh_result  (sh_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
`ifdef RSHIFT_CTRL_STICKY_EN
        .out_sticky (out_sticky),
`endif
        .busy       (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    rshift_req_t mq[$];
    logic        m_valid;
    logic [3:0]  m_data;
    logic        m_sticky;
    logic        m_push;
    logic        m_load;
    rshift_req_t m_req;

    // A queue of pending requests plus one held result.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_valid  = 1'b0;
            m_data   = 4'h0;
            m_sticky = 1'b0;
        end else begin
            m_push = in_valid && (mq.size() < DEPTH);
            m_load = (mq.size() > 0) && (!m_valid || out_ready);
            if (m_load) begin
                m_req    = mq.pop_front();
                m_data   = m_req.data >> m_req.amt;
                m_valid  = 1'b1;
`ifdef RSHIFT_CTRL_STICKY_EN
                m_sticky = m_req.sticky;
`endif
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
            if (m_push) begin
                m_req.data = in_data;
                m_req.amt  = in_amt;
`ifdef RSHIFT_CTRL_STICKY_EN
                m_req.sticky = ((in_data & ((4'b0001 << in_amt) - 4'b0001)) != 4'b0000);
`endif
                mq.push_back(m_req);
            end
        end
    end

    // Every falling edge: compare all outputs with the model.
    always @(negedge clk) begin
        check("in_ready", in_ready, rst_n && (mq.size() < DEPTH));
        check("out_valid", out_valid, m_valid);
        check("out_data", out_data, m_data);
        check("busy", busy, (mq.size() > 0) || m_valid);
        check("sh_data", sh_data, (mq.size() > 0) ? mq[0].data : 4'h0);
        check("sh_sel", sh_sel, (mq.size() > 0) ? mq[0].amt : 2'h0);
`ifdef RSHIFT_CTRL_STICKY_EN
        check("out_sticky", out_sticky, m_sticky);
`endif
    end

    // Apply inputs, let one rising edge happen, settle just after the falling edge.
    task automatic step(input logic v, input logic [3:0] d, input logic [1:0] a, input logic r);
        in_valid  = v;
        in_data   = d;
        in_amt    = a;
        out_ready = r;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    logic [3:0] b2b_exp [4];

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = 4'h0; in_amt = 2'h0; out_ready = 1'b0;
        b2b_exp[0] = 4'b1011; b2b_exp[1] = 4'b0101; b2b_exp[2] = 4'b0010; b2b_exp[3] = 4'b0001;

        repeat (2) @(negedge clk);
        #1;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 4'h0);
        check("rst_busy", busy, 1'b0);
        rst_n = 1'b1;

        // Single request: result one cycle after acceptance.
        step(1'b1, 4'b1011, 2'd1, 1'b1);
        check("single_not_yet", out_valid, 1'b0);
        step(1'b0, 4'h0, 2'd0, 1'b1);
        check("single_valid", out_valid, 1'b1);
        check("single_data", out_data, 4'b0101);
`ifdef RSHIFT_CTRL_STICKY_EN
        check("single_sticky", out_sticky, 1'b1);
`endif
        step(1'b0, 4'h0, 2'd0, 1'b1);
        check("single_drained", out_valid, 1'b0);
        check("single_idle", busy, 1'b0);

        // Back-to-back at full throughput.
        for (int i = 0; i < 5; i++) begin
            step(i < 4, 4'b1011, 2'(i), 1'b1);
            if (i >= 1) begin
                check("b2b_valid", out_valid, 1'b1);
                check("b2b_data", out_data, b2b_exp[i-1]);
            end
        end
        step(1'b0, 4'h0, 2'd0, 1'b1);
        check("b2b_end", out_valid, 1'b0);

        // Backpressure: hold first result, FIFO fills, then drain in order.
        step(1'b1, 4'b1100, 2'd2, 1'b0);
        step(1'b1, 4'b1111, 2'd1, 1'b0);
        check("bp_first_valid", out_valid, 1'b1);
        check("bp_first_data", out_data, 4'b0011);
        step(1'b1, 4'b1001, 2'd0, 1'b0);
        check("bp_full", in_ready, 1'b0);
        check("bp_hold_data", out_data, 4'b0011);
        step(1'b1, 4'b0110, 2'd1, 1'b0);
        check("bp_still_full", in_ready, 1'b0);
        check("bp_hold_valid", out_valid, 1'b1);
        check("bp_hold_data2", out_data, 4'b0011);
        step(1'b0, 4'h0, 2'd0, 1'b1);
        check("bp_drain1", out_data, 4'b0111);
        step(1'b0, 4'h0, 2'd0, 1'b1);
        check("bp_drain2", out_data, 4'b1001);
        step(1'b0, 4'h0, 2'd0, 1'b1);
        check("bp_drained", out_valid, 1'b0);

        // Asynchronous reset with two entries queued and a result held.
        step(1'b1, 4'b1100, 2'd2, 1'b0);
        step(1'b1, 4'b1111, 2'd1, 1'b0);
        step(1'b1, 4'b1001, 2'd0, 1'b0);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_in_ready", in_ready, 1'b0);
        check("arst_out_data", out_data, 4'h0);
        @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b1, 4'b1000, 2'd3, 1'b1);
        step(1'b0, 4'h0, 2'd0, 1'b1);
        check("post_rst_valid", out_valid, 1'b1);
        check("post_rst_data", out_data, 4'b0001);
        step(1'b0, 4'h0, 2'd0, 1'b1);
        check("post_rst_idle", busy, 1'b0);

`ifdef RSHIFT_CTRL_STICKY_EN
        step(1'b1, 4'b0100, 2'd2, 1'b1);
        step(1'b0, 4'h0, 2'd0, 1'b1);
        check("sticky0_data", out_data, 4'b0001);
        check("sticky0_flag", out_sticky, 1'b0);
        step(1'b1, 4'b0110, 2'd2, 1'b1);
        step(1'b0, 4'h0, 2'd0, 1'b1);
        check("sticky1_data", out_data, 4'b0001);
        check("sticky1_flag", out_sticky, 1'b1);
`endif

        // Randomized traffic with varying backpressure.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 60, 4'($urandom), 2'($urandom),
                 $urandom_range(0, 99) < ((i < 1500) ? 75 : 30));
        end
        repeat (4) step(1'b0, 4'h0, 2'd0, 1'b1);
        check("final_idle", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
